// File: rtl/gray_ctr_pkg.sv
// Shared constants, operation encoding and binary-to-Gray conversion
// for the Gray up/down counter.
package gray_ctr_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_STEP,
    OP_LOAD
  } op_e;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational WIDTH-bit binary-to-Gray encoder.
module gray_enc
  import gray_ctr_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin_i,
  output logic [WIDTH-1:0] gray_o
);

  logic [31:0] gray_full;

  assign gray_full = bin2gray(32'(bin_i));
  assign gray_o    = gray_full[WIDTH-1:0];

endmodule

// File: rtl/gray_updn_ctr.sv
// Binary up/down counter with registered Gray view, load, and selectable
// wrap or saturate behaviour at the 0 / all-ones boundaries.
module gray_updn_ctr
  import gray_ctr_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned SAT_MODE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             wrap,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;
  localparam bit               SAT_EN  = (SAT_MODE == MODE_SAT);

  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             sat_q,  sat_d;

  op_e              op;
  logic             at_bound;
  logic [WIDTH-1:0] step_val;

  always_comb begin
    op = OP_HOLD;
    if (load)    op = OP_LOAD;
    else if (en) op = OP_STEP;
  end

  // Boundary is direction-dependent: all-ones when counting up, zero when down.
  always_comb begin
    at_bound = up ? (bin_q == MAX_VAL) : (bin_q == '0);
    step_val = up ? (bin_q + 1'b1) : (bin_q - 1'b1);
  end

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    sat_d  = sat_q;
    unique case (op)
      OP_LOAD: begin
        bin_d = load_val;
        sat_d = SAT_EN && ((load_val == '0) || (load_val == MAX_VAL));
      end
      OP_STEP: begin
        if (SAT_EN && at_bound) begin
          sat_d = 1'b1;
        end else begin
          bin_d  = step_val;
          wrap_d = !SAT_EN && at_bound;
          sat_d  = SAT_EN && ((step_val == '0) || (step_val == MAX_VAL));
        end
      end
      default: ;
    endcase
  end

  gray_enc #(.WIDTH(WIDTH)) u_enc (
    .bin_i  (bin_d),
    .gray_o (gray_d)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bin_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
    end
  end

  assign bin_out  = bin_q;
  assign gray_out = gray_q;
  assign wrap     = wrap_q;
  assign sat      = sat_q;

endmodule

// File: tb/tb_gray_updn_ctr.sv
// Scoreboard bench for gray_updn_ctr: a wrapping and a saturating instance
// share stimulus; expected results are queued and checked by a monitor.
module tb_gray_updn_ctr;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_val = '0;

  logic [3:0] gw, bw, gs, bs;
  logic       ww, sw, ws, ss;

  always #5 clk = ~clk;

  gray_updn_ctr #(.WIDTH(4), .SAT_MODE(0)) u_wrap (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .load_val(load_val),
    .gray_out(gw), .bin_out(bw), .wrap(ww), .sat(sw)
  );

  gray_updn_ctr #(.WIDTH(4), .SAT_MODE(1)) u_sat (
    .clk(clk), .rstn(rstn), .en(en), .up(up), .load(load), .load_val(load_val),
    .gray_out(gs), .bin_out(bs), .wrap(ws), .sat(ss)
  );

  typedef struct {
    bit         sel;
    logic [3:0] bin;
    logic [3:0] gray;
    logic       flag;
    int         id;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_vec  = 0;
  int   n_miss = 0;
  int   vec_id = 0;
  bit   inv_on = 1'b0;
  logic [3:0] prev_gw, prev_gs;

  localparam logic [3:0] G [16] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                                    4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};

  task automatic drive(input bit r, input bit e_i, input bit u, input bit l,
                       input logic [3:0] v, input bit sel,
                       input logic [3:0] b, input logic [3:0] g, input logic f);
    @(negedge clk);
    rstn = r; en = e_i; up = u; load = l; load_val = v;
    q.push_back('{sel, b, g, f, vec_id});
    vec_id++;
  endtask

  // Monitor: one sample per edge, away from the active edge.
  always begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (!e.sel) begin
        if ({bw, gw, ww, sw} !== {e.bin, e.gray, e.flag, 1'b0}) begin
          n_miss++;
          $display("FAIL vec%0d wrap_dut got bin=%h gray=%h wrap=%b sat=%b exp bin=%h gray=%h wrap=%b sat=0",
                   e.id, bw, gw, ww, sw, e.bin, e.gray, e.flag);
        end
      end else begin
        if ({bs, gs, ss, ws} !== {e.bin, e.gray, e.flag, 1'b0}) begin
          n_miss++;
          $display("FAIL vec%0d sat_dut got bin=%h gray=%h sat=%b wrap=%b exp bin=%h gray=%h sat=%b wrap=0",
                   e.id, bs, gs, ss, ws, e.bin, e.gray, e.flag);
        end
      end
    end
    if (inv_on) begin
      n_vec++;
      if (gw !== (bw ^ (bw >> 1)) || gs !== (bs ^ (bs >> 1))) begin
        n_miss++;
        $display("FAIL gray_inv got gw=%h bw=%h gs=%h bs=%h", gw, bw, gs, bs);
      end
      if (rstn && !load && en) begin
        n_vec++;
        if ($countones(gw ^ prev_gw) != 1 || $countones(gs ^ prev_gs) > 1) begin
          n_miss++;
          $display("FAIL gray_step got gw %h->%h gs %h->%h exp one-bit change",
                   prev_gw, gw, prev_gs, gs);
        end
      end
    end
    prev_gw = gw;
    prev_gs = gs;
  end

  logic [3:0] mb, v;
  logic       w;
  bit         r, ee, u, l;

  initial begin
    // reset, both instances
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 4'h0, 4'h0, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 1'b1, 4'h0, 4'h0, 1'b0);
    inv_on = 1'b1;
    // full up-count with wrap
    for (int k = 1; k <= 16; k++)
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'(k), G[k % 16], (k == 16));
    drive(1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    // down from zero wraps to all-ones
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'hF, 4'h8, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'hF, 4'h8, 1'b0);
    // load beats enable; direction change without dead cycle
    drive(1'b1, 1'b1, 1'b1, 1'b1, 4'hA, 1'b0, 4'hA, 4'hF, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 4'h9, 4'hD, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'hA, 4'hF, 1'b0);
    // reset mid-count overrides load and enable
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0);
    for (int k = 1; k <= 7; k++)
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'(k), G[k], 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'h5, 1'b0, 4'h0, 4'h0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 4'h1, 4'h1, 1'b0);
    // saturating instance
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'hE, 1'b1, 4'hE, 4'h9, 1'b0);
    for (int k = 0; k < 3; k++)
      drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'hF, 4'h8, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'hE, 4'h9, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'h0, 1'b1, 4'h0, 4'h0, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b1, 4'h0, 4'h0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 4'h0, 1'b1, 4'h1, 4'h1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 4'hF, 4'h8, 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 4'h3, 1'b1, 4'h3, 4'h2, 1'b0);

    // random traffic against a modulo-16 reference for the wrapping instance
    mb = '0;
    for (int i = 0; i < 10000; i++) begin
      r  = (i == 0) ? 1'b0 : ($urandom_range(63) != 0);
      l  = ($urandom_range(15) == 0);
      ee = ($urandom_range(3) != 0);
      u  = 1'($urandom_range(1));
      v  = 4'($urandom_range(15));
      w  = 1'b0;
      if (!r) mb = 4'h0;
      else if (l) mb = v;
      else if (ee) begin
        if (u) begin w = (mb == 4'hF); mb = mb + 4'h1; end
        else   begin w = (mb == 4'h0); mb = mb - 4'h1; end
      end
      drive(r, ee, u, l, v, 1'b0, mb, mb ^ (mb >> 1), w);
    end

    @(negedge clk);
    en = 1'b0; load = 1'b0;
    for (int t = 0; t < 20 && q.size() > 0; t++) @(negedge clk);
    if (q.size() > 0) begin
      n_vec++;
      n_miss++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/gray_updn_ctr.md
GRAY_UPDN_CTR -- requirements
Module: gray_updn_ctr

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits; legal range 2..32.
REQ-002 Parameter SAT_MODE, default 0, boundary behaviour: 0 = wrap, 1 = saturate.
REQ-003 Port clk  input  1  rising-edge clock; only clock of the block.
REQ-004 Port rstn  input  1  reset, synchronous to clk, active-low.
REQ-005 Port en  input  1  count enable; one step per clk edge while high.
REQ-006 Port up  input  1  direction, sampled with en: 1 = increment, 0 = decrement.
REQ-007 Port load  input  1  synchronous load strobe.
REQ-008 Port load_val  input  WIDTH  binary value to load.
REQ-009 Port gray_out  output  WIDTH  registered Gray-coded count.
REQ-010 Port bin_out  output  WIDTH  registered binary count, same cycle as gray_out.
REQ-011 Port wrap  output  1  registered one-cycle pulse on wrap-around (SAT_MODE=0 only).
REQ-012 Port sat  output  1  registered level, high while held at a boundary (SAT_MODE=1 only).

Function
REQ-013 Internal state is a WIDTH-bit binary register B; gray_out SHALL equal B ^ (B >> 1), registered in the same edge as B.
REQ-014 Priority per edge: rstn low > load > en > hold.
REQ-015 load high: B <= load_val next edge, regardless of en/up; wrap <= 0; sat <= 1 if SAT_MODE=1 and load_val is 0 or 2^WIDTH-1, else 0.
REQ-016 en high, load low, up=1: B <= B+1; up=0: B <= B-1; latency one cycle from sampled en to updated outputs.
REQ-017 SAT_MODE=0, up=1 at B=2^WIDTH-1: B <= 0, wrap pulses high for exactly that cycle.
REQ-018 SAT_MODE=0, up=0 at B=0: B <= 2^WIDTH-1, wrap pulses high for exactly that cycle.
REQ-019 SAT_MODE=1 at boundary with step toward it: B holds, sat high; sat clears on first step away or a load of a non-boundary value.
REQ-020 SAT_MODE=1: wrap SHALL stay 0; SAT_MODE=0: sat SHALL stay 0.
REQ-021 en low, load low: all outputs hold; wrap returns to 0.
REQ-022 Every en-driven step SHALL change exactly one gray_out bit (wrap included); load is exempt.
REQ-023 up changing while en high takes effect on the same edge it is sampled; no dead cycle.

Reset
REQ-024 rstn low at a clk edge: B=0, gray_out=0, bin_out=0, wrap=0, sat=0, all inputs ignored.
REQ-025 Reset asserted mid-count overrides load and en in that cycle; counting resumes from 0 on the first edge with rstn high and en high.
REQ-026 No asynchronous reset path; outputs unaffected by rstn between clk edges.

Structure
REQ-027 Shared package gray_ctr_pkg SHALL hold constants MODE_WRAP=0, MODE_SAT=1 and the bin-to-Gray function.
REQ-028 One sub-module gray_enc (WIDTH-parametrised combinational bin-to-Gray) SHALL feed the gray_out register; counter, boundary and flag logic stay in gray_updn_ctr.
REQ-029 All outputs SHALL come directly from flops; no combinational input-to-output path.

Verification (WIDTH=4)
REQ-030 rstn low 2 cycles, then high, en=1, up=1 for 16 cycles -> gray_out 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8, then 0 with wrap=1 one cycle.
REQ-031 From reset, en=1, up=0, one cycle -> bin_out=0xF, gray_out=0x8, wrap=1 one cycle.
REQ-032 load=1, load_val=0xA, en=1 same cycle -> bin_out=0xA, gray_out=0xF, no step applied.
REQ-033 SAT_MODE=1, load 0xE, up=1 for 3 cycles -> bin_out 0xF, 0xF, 0xF; sat=1 from first reach; then up=0 one step -> 0xE, sat=0.
REQ-034 Count to bin_out=0x7, drop rstn for one edge with en=1 and load=1 -> all outputs 0; next enabled edge -> bin_out=0x1.
REQ-035 Random en/up/load for 10000 cycles, checker: gray_out == bin_out ^ (bin_out>>1) every cycle; single-bit Gray change on every en-only step.
